// File: rtl/hazard_fwd_unit.sv
// Stall/forward controller for the 5-stage MIPS pipeline: E/M/W scoreboard vs. D-stage Tuse.
// Optional MDU busy tracking is enabled by defining MDU_TRACK_EN.
module hazard_fwd_unit #(
  parameter int NREAD   = 2,
  parameter int AW      = 5,
  parameter int TW      = 2,
  parameter int MDU_LAT = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREAD*AW-1:0] src_D,
  input  logic [NREAD*TW-1:0] tuse_D,
  input  logic [AW-1:0]       dst_D,
  input  logic                we_D,
  input  logic [TW-1:0]       tnew_D,
  input  logic                mdu_start_D,
  input  logic                mdu_use_D,
  output logic                stall,
  output logic [NREAD*2-1:0]  fwd_sel_D,
  output logic [NREAD*2-1:0]  fwd_sel_E
);

  logic [AW-1:0]       dst_e, dst_m, dst_w;
  logic                we_e, we_m, we_w;
  logic [TW-1:0]       tnew_e, tnew_m, tnew_w;
  logic [NREAD*AW-1:0] src_e;
  logic                stall_hz, stall_mdu, stall_raw;

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      dst_e  <= '0; we_e <= 1'b0; tnew_e <= '0; src_e <= '0;
      dst_m  <= '0; we_m <= 1'b0; tnew_m <= '0;
      dst_w  <= '0; we_w <= 1'b0; tnew_w <= '0;
    end else begin
      dst_w  <= dst_m;
      we_w   <= we_m;
      tnew_w <= dec_sat(tnew_m);
      dst_m  <= dst_e;
      we_m   <= we_e;
      tnew_m <= dec_sat(tnew_e);
      // a stalled D instruction leaves a bubble behind in E
      if (stall_raw) begin
        dst_e <= '0; we_e <= 1'b0; tnew_e <= '0; src_e <= '0;
      end else begin
        dst_e <= dst_D; we_e <= we_D; tnew_e <= tnew_D; src_e <= src_D;
      end
    end
  end

`ifdef MDU_TRACK_EN
  logic [2:0] mdu_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      mdu_cnt <= '0;
    else if (mdu_start_D && !stall_raw)
      mdu_cnt <= 3'(MDU_LAT);
    else if (mdu_cnt != 3'd0)
      mdu_cnt <= mdu_cnt - 3'd1;
  end

  assign stall_mdu = mdu_use_D && (mdu_cnt != 3'd0);
`else
  logic unused_mdu;
  assign unused_mdu = ^{mdu_start_D, mdu_use_D};
  assign stall_mdu  = 1'b0;
`endif

  always_comb begin
    logic [AW-1:0] s;
    logic [TW-1:0] tu;
    logic [TW-1:0] tw;
    logic [1:0]    code;
    logic          hit;
    s         = '0;
    tu        = '0;
    tw        = '0;
    code      = 2'b00;
    hit       = 1'b0;
    stall_hz  = 1'b0;
    fwd_sel_D = '0;
    fwd_sel_E = '0;
    for (int i = 0; i < NREAD; i++) begin
      s    = src_D[i*AW +: AW];
      tu   = tuse_D[i*TW +: TW];
      hit  = 1'b1;
      code = 2'b00;
      tw   = '0;
      // youngest producer wins
      if (we_e && dst_e != '0 && dst_e == s) begin
        code = 2'b01; tw = tnew_e;
      end else if (we_m && dst_m != '0 && dst_m == s) begin
        code = 2'b10; tw = tnew_m;
      end else if (we_w && dst_w != '0 && dst_w == s) begin
        code = 2'b11; tw = tnew_w;
      end else begin
        hit = 1'b0;
      end
      if (hit && tw == '0) fwd_sel_D[i*2 +: 2] = code;
      if (hit && tw > tu)  stall_hz = 1'b1;

      s = src_e[i*AW +: AW];
      if (we_m && dst_m != '0 && dst_m == s) begin
        if (tnew_m == '0) fwd_sel_E[i*2 +: 2] = 2'b10;
      end else if (we_w && dst_w != '0 && dst_w == s) begin
        if (tnew_w == '0) fwd_sel_E[i*2 +: 2] = 2'b11;
      end
    end
    if (reset) begin
      fwd_sel_D = '0;
      fwd_sel_E = '0;
    end
  end

  assign stall_raw = stall_hz || stall_mdu;
  assign stall     = stall_raw && !reset;

endmodule
